credit_arbiter: RTL and testbench

Shares a pool of MAX_CREDITS credits among NUM_REQ requesters with round-robin fairness. It is the controller for a shared up/down occupancy count, for example free slots in a shared FIFO or outstanding pipeline transactions. Requesters take one credit per grant, and the consumer returns credits on `ret`. The available-credit count is updated through a single adder whose second operand is muxed between +1, -1 and 0, never through a chained add/subtract.

---
 rtl/credit_arbiter.sv | 124 ++++++++++++
 tb/tb_credit_arbiter.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/credit_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : credit_arbiter
//  Description : Round-robin arbiter that hands out credits from a shared pool
//                of MAX_CREDITS and takes them back on ret. Setting the macro
//                CREDIT_ARB_ERR_EN adds a sticky err flag and assertions for
//                an illegal return.
//  Revision    : 1.0 - initial release
// ============================================================================
module credit_arbiter #(
    parameter  int NUM_REQ     = 4,
    parameter  int MAX_CREDITS = 8,
    localparam int CW          = $clog2(MAX_CREDITS + 1)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NUM_REQ-1:0] req,
    output logic [NUM_REQ-1:0] gnt,
    input  logic               ret,
    output logic [CW-1:0]      avail,
    output logic               empty,
    output logic               err
);

    localparam int            PW            = $clog2(NUM_REQ);
    localparam logic [PW:0]   c_nreq        = (PW + 1)'(NUM_REQ);
    localparam logic [PW-1:0] c_last        = PW'(NUM_REQ - 1);
    localparam logic [CW-1:0] c_max_credits = CW'(MAX_CREDITS);

    logic [CW-1:0]      r_avail;
    logic [PW-1:0]      r_ptr;

    logic               w_elig;
    logic [NUM_REQ-1:0] w_gnt;
    logic [PW-1:0]      w_gnt_idx;
    logic               w_hit;
    logic [PW:0]        w_scan;
    logic [PW-1:0]      w_ptr_nxt;
    logic               w_take;
    logic               w_drop;
    logic [CW-1:0]      w_delta;
    logic [CW-1:0]      w_avail_nxt;

    // Only the registered count decides eligibility; a same-cycle return never
    // unlocks a grant. Grants are also blocked while reset is held.
    assign w_elig = rst_n && (r_avail != '0);

    always_comb begin
        w_gnt     = '0;
        w_gnt_idx = '0;
        w_hit     = 1'b0;
        w_scan    = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            w_scan = {1'b0, r_ptr} + (PW + 1)'(k);
            if (w_scan >= c_nreq) begin
                w_scan = w_scan - c_nreq;
            end
            if (!w_hit && w_elig && req[w_scan[PW-1:0]]) begin
                w_hit                    = 1'b1;
                w_gnt_idx                = w_scan[PW-1:0];
                w_gnt[w_scan[PW-1:0]]    = 1'b1;
            end
        end
    end

    assign gnt       = w_gnt;
    assign w_take    = w_hit;
    assign w_ptr_nxt = (w_gnt_idx == c_last) ? '0 : w_gnt_idx + PW'(1);

    // A return into a full pool is discarded rather than wrapping the count.
    assign w_drop = ret && !w_take && (r_avail == c_max_credits);

    always_comb begin
        w_delta = '0;
        case ({ret, w_take})
            2'b10:   w_delta = w_drop ? '0 : CW'(1);
            2'b01:   w_delta = '1;
            default: w_delta = '0;
        endcase
    end

    assign w_avail_nxt = r_avail + w_delta;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_avail <= c_max_credits;
            r_ptr   <= '0;
        end else begin
            r_avail <= w_avail_nxt;
            if (w_take) begin
                r_ptr <= w_ptr_nxt;
            end
        end
    end

    assign avail = r_avail;
    assign empty = (r_avail == '0);

`ifdef CREDIT_ARB_ERR_EN
    logic r_err;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_err <= 1'b0;
        end else if (w_drop) begin
            r_err <= 1'b1;
        end
    end

    assign err = r_err;

    a_no_overflow_return: assert property (
        @(posedge clk) disable iff (!rst_n) !w_drop
    ) else $error("credit_arbiter: credit returned into a full pool");

    a_gnt_onehot0: assert property (
        @(posedge clk) disable iff (!rst_n) $onehot0(w_gnt)
    ) else $error("credit_arbiter: more than one grant in a cycle");
`else
    assign err = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_credit_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_credit_arbiter
//  Description : Scoreboard bench for credit_arbiter (NUM_REQ=4, MAX_CREDITS=8)
//                using directed vectors with hand-computed expectations.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_credit_arbiter;

    logic       clk;
    logic       rst_n;
    logic [3:0] req;
    logic [3:0] gnt;
    logic       ret;
    logic [3:0] avail;
    logic       empty;
    logic       err;

    credit_arbiter #(
        .NUM_REQ     (4),
        .MAX_CREDITS (8)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .req   (req),
        .gnt   (gnt),
        .ret   (ret),
        .avail (avail),
        .empty (empty),
        .err   (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string      name;
        logic [3:0] gnt;
        logic [3:0] avail;
        logic       empty;
        logic       err;
    } exp_t;

    exp_t q_exp[$];
    int   n_cmp  = 0;
    int   n_fail = 0;
    logic exp_err = 1'b0;

    task automatic push(input string nm, input logic [3:0] g, input logic [3:0] a);
        exp_t e;
        e.name  = nm;
        e.gnt   = g;
        e.avail = a;
        e.empty = (a == 4'd0);
        e.err   = exp_err;
        q_exp.push_back(e);
    endtask

    // Drive one cycle of stimulus and record what the DUT must show in it.
    task automatic step(input string nm, input logic [3:0] r, input logic rt,
                        input logic [3:0] g, input logic [3:0] a);
        req = r;
        ret = rt;
        push(nm, g, a);
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        req   = 4'b1111;
        ret   = 1'b0;
        exp_err = 1'b0;
        @(posedge clk);
        #1;
        push("reset", 4'b0000, 4'd8);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    always @(negedge clk) begin
        while (q_exp.size() > 0) begin
            exp_t e;
            e = q_exp.pop_front();
            n_cmp++;
            if (gnt !== e.gnt || avail !== e.avail || empty !== e.empty || err !== e.err) begin
                n_fail++;
                $display("FAIL %s: got gnt=%b avail=%0d empty=%b err=%b, expected gnt=%b avail=%0d empty=%b err=%b",
                         e.name, gnt, avail, empty, err, e.gnt, e.avail, e.empty, e.err);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, expected completion before 200000");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0;
        req   = 4'b0000;
        ret   = 1'b0;

        // Reset and drain with a single requester
        do_reset();
        for (int i = 0; i < 8; i++) begin
            step("drain", 4'b0001, 1'b0, 4'b0001, 4'(8 - i));
        end
        step("drain_empty", 4'b0001, 1'b0, 4'b0000, 4'd0);

        // Round-robin over all four requesters
        do_reset();
        for (int i = 0; i < 8; i++) begin
            step("rr", 4'b1111, 1'b0, 4'(1 << (i % 4)), 4'(8 - i));
        end
        step("rr_empty", 4'b1111, 1'b0, 4'b0000, 4'd0);

        // Idle requesters skipped from pointer 1
        do_reset();
        step("skip_setup", 4'b0001, 1'b0, 4'b0001, 4'd8);
        step("skip_p1",    4'b0101, 1'b0, 4'b0100, 4'd7);
        step("skip_p3",    4'b0101, 1'b0, 4'b0001, 4'd6);
        step("skip_p1b",   4'b0101, 1'b0, 4'b0100, 4'd5);

        // Simultaneous take and return leave the count unchanged
        do_reset();
        for (int i = 0; i < 5; i++) begin
            step("sim_setup", 4'b0010, 1'b0, 4'b0010, 4'(8 - i));
        end
        for (int i = 0; i < 5; i++) begin
            step("sim_take_ret", 4'b0010, 1'b1, 4'b0010, 4'd3);
        end
        for (int i = 0; i < 3; i++) begin
            step("sim_drain", 4'b0010, 1'b0, 4'b0010, 4'(3 - i));
        end
        step("sim_empty_ret", 4'b0010, 1'b1, 4'b0000, 4'd0);
        step("sim_after_ret", 4'b0000, 1'b0, 4'b0000, 4'd1);

        // Return into a full pool is dropped
        do_reset();
        step("ovf_ret", 4'b0000, 1'b1, 4'b0000, 4'd8);
`ifdef CREDIT_ARB_ERR_EN
        exp_err = 1'b1;
`endif
        step("ovf_after", 4'b0000, 1'b0, 4'b0000, 4'd8);
        step("ovf_take",  4'b1000, 1'b0, 4'b1000, 4'd8);
        step("ovf_refill", 4'b0000, 1'b1, 4'b0000, 4'd7);
        step("ovf_full",  4'b0000, 1'b0, 4'b0000, 4'd8);

        // Asynchronous reset in the middle of a cycle
        do_reset();
        for (int i = 0; i < 6; i++) begin
            step("mid_setup", 4'b1111, 1'b0, 4'(1 << (i % 4)), 4'(8 - i));
        end
        req = 4'b1111;
        #1;
        rst_n = 1'b0;
        exp_err = 1'b0;
        push("mid_reset", 4'b0000, 4'd8);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        step("mid_first", 4'b1111, 1'b0, 4'b0001, 4'd8);
        step("mid_second", 4'b1111, 1'b0, 4'b0010, 4'd7);

        @(negedge clk);
        #1;
        n_cmp++;
        if (q_exp.size() != 0) begin
            n_fail++;
            $display("FAIL drain_queue: got %0d pending entries, expected 0", q_exp.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
